// File: rtl/div_pkg.sv
// Shared constants, FSM state encoding and the div opcode encoding that is
// also used by the decoder.
package div_pkg;

  localparam int DATA_W = 32;
  localparam int ITER   = 32;
  localparam int CNT_W  = $clog2(ITER);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  typedef enum logic [1:0] {
    OP_DIV_W  = 2'd0,
    OP_MOD_W  = 2'd1,
    OP_DIV_WU = 2'd2,
    OP_MOD_WU = 2'd3
  } div_op_e;

  function automatic logic op_is_signed(input div_op_e op);
    return (op == OP_DIV_W) || (op == OP_MOD_W);
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage and the divider.
interface div_unit_if;
  import div_pkg::*;

  logic              div_en;
  logic              div_signed;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic              flush;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;

  modport master (
    output div_en, div_signed, dividend, divisor, flush,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  div_en, div_signed, dividend, divisor, flush,
    output busy, done, quotient, remainder
  );
endinterface

// File: rtl/div_unit.sv
// Restoring radix-2 divider: one quotient bit per BUSY cycle, sign fixed up
// on the final iteration so quotient/remainder are registered in DONE.
module div_unit #(
  parameter int DATA_W = div_pkg::DATA_W,
  parameter int ITER   = div_pkg::ITER
) (
  input  logic      clk,
  input  logic      reset,
  div_unit_if.slave dif
);
  import div_pkg::*;

  div_state_e          state_q, state_d;
  logic [DATA_W-1:0]   dvd_q, dvd_d, dvs_q, dvs_d, quo_q, quo_d;
  logic [DATA_W:0]     rem_q, rem_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic [DATA_W-1:0]   quot_q, quot_d, rmd_q, rmd_d;
  logic [DATA_W:0]     shifted, diff;
  logic                nonneg, accept;

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic sgn);
    return (sgn && v[DATA_W-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  assign accept  = (state_q == S_IDLE) && dif.div_en && !dif.flush;
  assign shifted = {rem_q[DATA_W-1:0], dvd_q[DATA_W-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  // A set top bit would mean the shifted value exceeds any divisor magnitude.
  assign nonneg  = !diff[DATA_W] || rem_q[DATA_W];

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    quot_d  = quot_q;
    rmd_d   = rmd_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_BUSY;
          dvd_d   = mag(dif.dividend, dif.div_signed);
          dvs_d   = mag(dif.divisor, dif.div_signed);
          q_neg_d = dif.div_signed && (dif.dividend[DATA_W-1] ^ dif.divisor[DATA_W-1]);
          r_neg_d = dif.div_signed && dif.dividend[DATA_W-1];
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
        end
      end
      S_BUSY: begin
        if (dif.flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d = nonneg ? diff : shifted;
          quo_d = {quo_q[DATA_W-2:0], nonneg};
          dvd_d = {dvd_q[DATA_W-2:0], 1'b0};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITER - 1)) begin
            state_d = S_DONE;
            quot_d  = neg_if(quo_d, q_neg_q);
            rmd_d   = neg_if(rem_d[DATA_W-1:0], r_neg_q);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      quot_q  <= '0;
      rmd_q   <= '0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      quot_q  <= quot_d;
      rmd_q   <= rmd_d;
    end
  end

  assign dif.busy      = (state_q == S_BUSY);
  assign dif.done      = (state_q == S_DONE);
  assign dif.quotient  = quot_q;
  assign dif.remainder = rmd_q;

endmodule

// File: tb/tb_div_unit.sv
// Divider bench: arithmetic reference model plus per-cycle compare, directed
// literal cases and a randomized stream with flushes.
module tb_div_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  div_unit_if dif ();

  div_unit u_dut (
    .clk   (clk),
    .reset (reset),
    .dif   (dif)
  );

  always #5 clk = ~clk;

  // Reference: plain magnitude division, zero divisor gives all-ones / dividend.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r);
    logic [31:0] ma, mb, qm, rm;
    ma = (s && a[31]) ? 32'(0 - a) : a;
    mb = (s && b[31]) ? 32'(0 - b) : b;
    if (mb == 32'd0) begin
      qm = 32'hFFFF_FFFF;
      rm = ma;
    end else begin
      qm = ma / mb;
      rm = ma % mb;
    end
    q = (s && (a[31] ^ b[31])) ? 32'(0 - qm) : qm;
    r = (s && a[31]) ? 32'(0 - rm) : rm;
  endfunction

  // k = cycles since accept: 1..32 busy, 33 done, 0 idle
  int          k = 0;
  bit          hold_ok = 1'b1;
  logic [31:0] m_q = '0, m_r = '0, h_q = '0, h_r = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      k = 0; hold_ok = 1'b1; h_q = '0; h_r = '0;
    end else if (k == 0) begin
      if (dif.div_en && !dif.flush) begin
        ref_div(dif.dividend, dif.divisor, dif.div_signed, m_q, m_r);
        k = 1;
        hold_ok = 1'b0;
      end
    end else if (k <= 32) begin
      if (dif.flush) k = 0;
      else k = k + 1;
    end else begin
      k = 0; hold_ok = 1'b1; h_q = m_q; h_r = m_r;
    end
  end

  always @(negedge clk) begin
    nvec++;
    if (dif.busy !== (k >= 1 && k <= 32) || dif.done !== (k == 33)) begin
      nerr++;
      $display("FAIL ctl t=%0t busy=%b done=%b expected k=%0d", $time, dif.busy, dif.done, k);
    end
    if (k == 33 || (k == 0 && hold_ok)) begin
      nvec++;
      if (dif.quotient !== (k == 33 ? m_q : h_q) || dif.remainder !== (k == 33 ? m_r : h_r)) begin
        nerr++;
        $display("FAIL result t=%0t q=%h r=%h required q=%h r=%h", $time, dif.quotient,
                 dif.remainder, (k == 33 ? m_q : h_q), (k == 33 ? m_r : h_r));
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s got=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(posedge clk); #2;
    dif.div_en = 1'b1; dif.div_signed = s; dif.dividend = a; dif.divisor = b;
  endtask

  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] eq, input logic [31:0] er);
    int  cyc;
    bit  got;
    start(a, b, s);
    cyc = 0; got = 1'b0;
    while (cyc < 40 && !got) begin
      @(posedge clk); #2;
      cyc++;
      got = dif.done;
    end
    chk({nm, " latency"}, 32'(cyc), 32'd33);
    chk({nm, " q"}, dif.quotient, eq);
    chk({nm, " r"}, dif.remainder, er);
    @(posedge clk); #2;
    chk({nm, " no-restart"}, {30'd0, dif.busy, dif.done}, 32'd0);
    dif.div_en = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      4:       return 32'($urandom % 16);
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int seen;
    dif.div_en = 1'b0; dif.div_signed = 1'b0; dif.dividend = '0; dif.divisor = '0;
    dif.flush = 1'b0;
    #1 reset = 1'b1;
    #1 chk("reset state", {dif.busy, dif.done, 30'd0} | dif.quotient | dif.remainder, 32'd0);
    @(posedge clk); #2 reset = 1'b0;

    run_op("u 100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
    run_op("s -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_op("s 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1);
    run_op("s ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
    run_op("u 5/0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5);
    run_op("s -5/0", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'h0000_0001, 32'hFFFF_FFFB);

    // flush in the tenth busy cycle
    start(32'd1000, 32'd3, 1'b0);
    repeat (10) begin @(posedge clk); #2; end
    chk("flush pre busy", {31'd0, dif.busy}, 32'd1);
    dif.flush = 1'b1;
    @(posedge clk); #2;
    chk("flush busy drop", {31'd0, dif.busy}, 32'd0);
    dif.flush = 1'b0; dif.div_en = 1'b0;
    seen = 0;
    repeat (36) begin @(posedge clk); #2; if (dif.done) seen++; end
    chk("flush no done", 32'(seen), 32'd0);
    run_op("u 9/3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0);

    // asynchronous reset in the fifteenth busy cycle
    start(32'd12345, 32'd7, 1'b0);
    repeat (15) begin @(posedge clk); #2; end
    #1 reset = 1'b1;
    #1 chk("async reset", {dif.busy, dif.done, 30'd0} | dif.quotient | dif.remainder, 32'd0);
    @(posedge clk); #2 reset = 1'b0; dif.div_en = 1'b0;
    run_op("u ffffffff/16", 32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 32'hF);

    // randomized stream; the per-cycle compare does the checking
    repeat (6000) begin
      @(posedge clk); #2;
      dif.div_en     = ($urandom % 8) != 0;
      dif.flush      = ($urandom % 64) == 0;
      dif.div_signed = 1'($urandom % 2);
      dif.dividend   = pick();
      dif.divisor    = pick();
    end
    @(posedge clk); #2;
    dif.div_en = 1'b0; dif.flush = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for the EX stage.
- Serves div.w/mod.w (signed) and div.wu/mod.wu (unsigned).
- Restoring radix-2 algorithm, one quotient bit per cycle. Quotient and remainder are produced together.
- ex_level drives a request and holds calculate_stall while the request is pending and done is low. Divider results enter es_to_ms_bus in the cycle done is high.

Parameters:
- DATA_W, 32, operand/result width (only 32 is supported).
- ITER, 32, iteration count; must equal DATA_W.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- div_en  input  1  request valid; level signal, held by EX while the instruction stalls in EX
- div_signed  input  1  1 = signed (div.w/mod.w), 0 = unsigned
- dividend  input  32  operand rj
- divisor  input  32  operand rk
- flush  input  1  cancel in-flight op (EX flushed by branch_cancel)
- busy  output  1  high in BUSY state
- done  output  1  one-cycle pulse; quotient/remainder valid in this cycle
- quotient  output  32  result
- remainder  output  32  result

Behaviour:
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> BUSY when div_en & ~flush.
  - BUSY -> DONE when iteration counter reaches ITER-1 and ~flush.
  - BUSY -> IDLE when flush.
  - DONE -> IDLE unconditionally.
- Accept (IDLE & div_en & ~flush, sampled at clk edge):
  - latch |dividend| and |divisor|, using two's-complement magnitude when div_signed and MSB = 1;
  - latch q_neg = div_signed & (dividend[31] ^ divisor[31]);
  - latch r_neg = div_signed & dividend[31];
  - clear 33-bit partial remainder; counter = 0.
- Each BUSY cycle:
  - shift partial remainder left, bringing in the next dividend MSB;
  - 33-bit trial subtract of divisor magnitude;
  - if non-negative: keep the difference, quotient bit = 1; otherwise quotient bit = 0;
  - counter increments.
- Latency: div_en rises in cycle 0 -> BUSY in cycles 1..32 -> done = 1 in cycle 33. Fixed, independent of operand values.
- In DONE:
  - quotient = q_neg ? -q_mag : q_mag;
  - remainder = r_neg ? -r_mag : r_mag, low 32 bits, two's complement wrap.
- quotient/remainder keep their value after DONE until the next accept.
- div_en is ignored in DONE. The same held request must not restart, because EX advances at the end of the done cycle. A new request is accepted no earlier than the cycle after done.
- Divide by zero (no trap; algorithm output with sign fix):
  - q_mag = 0xFFFFFFFF, r_mag = |dividend|;
  - unsigned 5/0 -> q = 0xFFFFFFFF, r = 5.
- Overflow: 0x80000000 / 0xFFFFFFFF signed -> q = 0x80000000, r = 0 (natural wrap).
- Flush:
  - BUSY -> IDLE at the next edge; done never asserts for the cancelled op; outputs are undefined and unused.
  - flush in DONE: done still pulses, and EX is expected to discard it.
  - flush and div_en in IDLE in the same cycle: no accept.
- Reset:
  - asynchronous, any state -> IDLE;
  - busy = 0, done = 0, quotient = 0, remainder = 0, counter = 0, partial remainder = 0.
  - Reset mid-operation discards the op, with no done.
- busy = (state == BUSY). done = (state == DONE).
- Stall contract for ex_level: calculate_stall = div_op & ~done.

Decomposition:
- Shared package (div_pkg):
  - DATA_W, ITER constants;
  - FSM state localparams (S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2);
  - opcode-to-div_signed encoding shared with id_level.
- No sub-module needed. The abs/negate helpers are combinational functions inside div_unit.

Test Plan:
- Unsigned 100/7, div_en held:
  - done exactly in cycle 33, q = 14, r = 2;
  - done low in cycle 34 with div_en still high; no restart (busy stays 0).
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) -> q = 0xFFFFFFFD, r = 0xFFFFFFFF.
- Signed 7/-2 -> q = 0xFFFFFFFD, r = 1.
- Signed 0x80000000 / 0xFFFFFFFF -> q = 0x80000000, r = 0.
- Division by zero:
  - unsigned 5/0 -> q = 0xFFFFFFFF, r = 5;
  - signed -5/0 -> q = 0x00000001, r = 0xFFFFFFFB.
- Flush:
  - assert flush in cycle 10 of BUSY -> busy = 0 next cycle, no done;
  - then request 9/3 unsigned -> done 33 cycles later, q = 3, r = 0.
- Reset mid-op:
  - assert reset asynchronously (between edges) in cycle 15 of BUSY;
  - busy, done, quotient, remainder go to 0 immediately;
  - after release, 0xFFFFFFFF/0x10 unsigned -> q = 0x0FFFFFFF, r = 0xF.
